replace_event_queue: RTL

- Sits directly downstream of the speculative Replace Order ('U') decoder.
- Captures each completed replace message, on the decoder's one-cycle valid pulse with parsed type 4, into a small first-word-fall-through FIFO.
- Presents captured messages to the order-book stage over a valid/ready handshake, with a per-event sequence number.
- Counts rejected-message pulses and overflow drops for host visibility.

---
 rtl/itch_pkg.sv | 18 +
 rtl/replace_event_queue_if.sv | 34 +++
 rtl/sync_fifo_fwft.sv | 62 ++++++
 rtl/replace_event_queue.sv | 107 ++++++++++
 4 files changed

// File: rtl/itch_pkg.sv
// rtl/itch_pkg.sv - shared ITCH decoder types, constants and helpers
package itch_pkg;

    localparam logic [3:0] PARSED_TYPE_REPLACE = 4'd4;

    typedef struct packed {
        logic [63:0] old_ref;
        logic [63:0] new_ref;
        logic [31:0] shares;
        logic [31:0] price;
    } replace_evt_t;

    // Callers zero-extend into 64 bits and pass their own all-ones ceiling.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input logic [63:0] max_value);
        return (value >= max_value) ? max_value : value + 64'd1;
    endfunction

endpackage

// File: rtl/replace_event_queue_if.sv
// rtl/replace_event_queue_if.sv - decoder input bundle and event handshake bundle
interface replace_event_queue_if #(
    parameter int SEQ_W = 16
);
    logic             replace_internal_valid;
    logic             replace_packet_invalid;
    logic [3:0]       replace_parsed_type;
    logic [63:0]      replace_old_order_ref;
    logic [63:0]      replace_new_order_ref;
    logic [31:0]      replace_shares;
    logic [31:0]      replace_price;

    logic             evt_valid;
    logic             evt_ready;
    logic [63:0]      evt_old_ref;
    logic [63:0]      evt_new_ref;
    logic [31:0]      evt_shares;
    logic [31:0]      evt_price;
    logic [SEQ_W-1:0] evt_seq;

    modport slave (
        input  replace_internal_valid, replace_packet_invalid, replace_parsed_type,
        input  replace_old_order_ref, replace_new_order_ref, replace_shares, replace_price,
        input  evt_ready,
        output evt_valid, evt_old_ref, evt_new_ref, evt_shares, evt_price, evt_seq
    );

    modport master (
        output replace_internal_valid, replace_packet_invalid, replace_parsed_type,
        output replace_old_order_ref, replace_new_order_ref, replace_shares, replace_price,
        output evt_ready,
        input  evt_valid, evt_old_ref, evt_new_ref, evt_shares, evt_price, evt_seq
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - generic first-word-fall-through FIFO with level/full/empty
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_rd   = rd_en && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= AW'(wr_ptr + 1'b1);
            end
            if (do_rd) begin
                rd_ptr <= AW'(rd_ptr + 1'b1);
            end
            case ({do_wr, do_rd})
                2'b10:   level <= LW'(level + 1'b1);
                2'b01:   level <= LW'(level - 1'b1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/replace_event_queue.sv
// rtl/replace_event_queue.sv - replace-message event queue with sequencing and status counters
// Optional push filter: REPLACE_EVENT_QUEUE_FILTER_EN
module replace_event_queue
    import itch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 16,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    replace_event_queue_if.slave   bus,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]       drop_count,
    output logic [CNT_W-1:0]       invalid_count,
    output logic [CNT_W-1:0]       reject_count
);
    typedef struct packed {
        replace_evt_t     evt;
        logic [SEQ_W-1:0] seq;
    } entry_t;

    localparam logic [63:0] CNT_MAX = 64'({CNT_W{1'b1}});

    entry_t           wr_entry;
    entry_t           rd_entry;
    logic             push_req;
    logic             push_ok;
    logic             pop;
    logic             full;
    logic             empty;
    logic             drop;
    logic [SEQ_W-1:0] next_seq;

    assign push_req = bus.replace_internal_valid && (bus.replace_parsed_type == PARSED_TYPE_REPLACE);
    assign pop      = bus.evt_valid && bus.evt_ready;
    assign drop     = push_ok && full && !pop;

`ifdef REPLACE_EVENT_QUEUE_FILTER_EN
    logic filtered;
    assign filtered = push_req && ((bus.replace_shares == 32'd0) ||
                                   (bus.replace_old_order_ref == bus.replace_new_order_ref));
    assign push_ok  = push_req && !filtered;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reject_count <= '0;
        end else if (filtered) begin
            reject_count <= CNT_W'(sat_inc(64'(reject_count), CNT_MAX));
        end
    end
`else
    assign push_ok      = push_req;
    assign reject_count = '0;
`endif

    always_comb begin
        wr_entry             = '0;
        wr_entry.evt.old_ref = bus.replace_old_order_ref;
        wr_entry.evt.new_ref = bus.replace_new_order_ref;
        wr_entry.evt.shares  = bus.replace_shares;
        wr_entry.evt.price   = bus.replace_price;
        wr_entry.seq         = next_seq;
    end

    sync_fifo_fwft #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push_ok),
        .wr_data (wr_entry),
        .rd_en   (bus.evt_ready),
        .rd_data (rd_entry),
        .level   (fifo_level),
        .full    (full),
        .empty   (empty)
    );

    assign bus.evt_valid   = !empty;
    assign bus.evt_old_ref = rd_entry.evt.old_ref;
    assign bus.evt_new_ref = rd_entry.evt.new_ref;
    assign bus.evt_shares  = rd_entry.evt.shares;
    assign bus.evt_price   = rd_entry.evt.price;
    assign bus.evt_seq     = rd_entry.seq;

    // Dropped pushes still consume a sequence number so the consumer can see the gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_seq      <= '0;
            drop_count    <= '0;
            invalid_count <= '0;
        end else begin
            if (push_ok) begin
                next_seq <= SEQ_W'(next_seq + 1'b1);
            end
            if (drop) begin
                drop_count <= CNT_W'(sat_inc(64'(drop_count), CNT_MAX));
            end
            if (bus.replace_packet_invalid) begin
                invalid_count <= CNT_W'(sat_inc(64'(invalid_count), CNT_MAX));
            end
        end
    end

endmodule
